// File: rtl/adc_frame_align.sv
// -----------------------------------------------------------------------------
// adc_frame_align
//
// Word-alignment controller for the ADC capture path. Sits directly after the
// LVDS SERDES clocking block and runs on the divided SERDES clock.
//
// It watches the deserialized frame-clock lane and pulses the ISERDES bitslip
// input until the frame word equals FRAME_PATTERN for MATCH_COUNT consecutive
// cycles. After lock it keeps monitoring the frame lane and retrains after
// LOSS_COUNT consecutive mismatches. The 8-lane sample bus is registered and
// qualified with data_valid for the downstream FIFO.
//
// Parameters:
//   FRAME_PATTERN  expected frame-lane word when aligned
//   SLIP_WAIT      cycles ignored after start/bitslip (ISERDES settle), 1..15
//   MATCH_COUNT    consecutive matches required for lock, 1..255
//   MAX_SLIPS      bitslips attempted before declaring failure, 1..15
//   LOSS_COUNT     consecutive mismatches while locked that drop lock, 1..15
//
// Ports:
//   divclk      in   1   divided SERDES clock (only clock)
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   (re)start training; accepted in any state
//   frame_word  in   8   deserialized frame-clock lane word
//   data_in     in  64   deserialized sample lanes, 8 lanes x 8 bits
//   bitslip     out  1   one-cycle bitslip pulse to all ISERDES instances
//   aligned     out  1   high while locked
//   align_fail  out  1   sticky: MAX_SLIPS slips issued without lock
//   slip_count  out  4   bitslips issued in the current training attempt
//   err_count   out 16   saturating count of frame mismatches while locked
//   data_out    out 64   data_in delayed by one cycle (not gated)
//   data_valid  out  1   qualifies data_out; always equal to aligned
// -----------------------------------------------------------------------------
module adc_frame_align #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MATCH_COUNT   = 16,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic        divclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  frame_word,
    input  logic [63:0] data_in,
    output logic        bitslip,
    output logic        aligned,
    output logic        align_fail,
    output logic [3:0]  slip_count,
    output logic [15:0] err_count,
    output logic [63:0] data_out,
    output logic        data_valid
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } state_t;

    // Terminal values of the counters, sized to the counters they compare with.
    localparam logic [3:0]  SETTLE_LAST = 4'(SLIP_WAIT - 1);
    localparam logic [7:0]  MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [3:0]  SLIP_MAX    = 4'(MAX_SLIPS);
    localparam logic [3:0]  LOSS_LAST   = 4'(LOSS_COUNT - 1);

    state_t      state,      state_nxt;
    logic [3:0]  settle_cnt, settle_nxt;
    logic [7:0]  match_cnt,  match_nxt;
    logic [3:0]  miss_cnt,   miss_nxt;
    logic [3:0]  slip_nxt;
    logic [15:0] err_nxt;
    logic        bitslip_nxt;
    logic        fail_nxt;
    logic        frame_match;

    assign frame_match = (frame_word == FRAME_PATTERN);

    // -------------------------------------------------------------------------
    // State and counter register. All outputs are registered so that the
    // bitslip pulse reaches the ISERDES cleanly and aligned/data_valid stay
    // glitch-free.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            slip_count <= '0;
            err_count  <= '0;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            slip_count <= slip_nxt;
            err_count  <= err_nxt;
            bitslip    <= bitslip_nxt;
            align_fail <= fail_nxt;
            // aligned and data_valid share one source so they can never differ.
            aligned    <= (state_nxt == LOCKED);
            data_valid <= (state_nxt == LOCKED);
            data_out   <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-counter logic.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its hold value first; a path that forgets one
    // would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        settle_nxt  = settle_cnt;
        match_nxt   = match_cnt;
        miss_nxt    = miss_cnt;
        slip_nxt    = slip_count;
        err_nxt     = err_count;
        bitslip_nxt = 1'b0;
        fail_nxt    = align_fail;

        if (start) begin
            // Restart from any state; SETTLE counts from the last start cycle.
            state_nxt  = SETTLE;
            settle_nxt = '0;
            match_nxt  = '0;
            miss_nxt   = '0;
            slip_nxt   = '0;
            err_nxt    = '0;
            fail_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Wait for start.
                end

                SETTLE: begin
                    // frame_word is ignored while the ISERDES pipeline settles.
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt  = CHECK;
                        settle_nxt = '0;
                    end else begin
                        settle_nxt = settle_cnt + 4'd1;
                    end
                end

                CHECK: begin
                    if (frame_match) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + 8'd1;
                        end
                    end else begin
                        match_nxt = '0;
                        if (slip_count == SLIP_MAX) begin
                            state_nxt = FAIL;
                            fail_nxt  = 1'b1;
                        end else begin
                            // slip_count counts on entry to SLIP and can never
                            // pass SLIP_MAX because of the test above.
                            state_nxt   = SLIP;
                            bitslip_nxt = 1'b1;
                            slip_nxt    = slip_count + 4'd1;
                        end
                    end
                end

                SLIP: begin
                    // Single-cycle state: bitslip is high only while here, and
                    // the following SETTLE + CHECK guarantees the pulse spacing.
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end

                LOCKED: begin
                    if (frame_match) begin
                        miss_nxt = '0;
                    end else begin
                        if (err_count != 16'hFFFF) begin
                            err_nxt = err_count + 16'd1;
                        end
                        if (miss_cnt == LOSS_LAST) begin
                            // Lock lost: retrain, keeping the error history.
                            state_nxt  = SETTLE;
                            settle_nxt = '0;
                            slip_nxt   = '0;
                            match_nxt  = '0;
                            miss_nxt   = '0;
                        end else begin
                            miss_nxt = miss_cnt + 4'd1;
                        end
                    end
                end

                FAIL: begin
                    // Sticky until start or reset.
                    fail_nxt = 1'b1;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_align.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_align
//
// Self-checking bench for adc_frame_align with its default parameters.
// Expected timing is derived arithmetically: a clean lock takes
// SLIP_WAIT + MATCH_COUNT edges after start, and each failed attempt adds
// SLIP_WAIT settle + one CHECK + one SLIP cycle. The ISERDES is modelled as a
// rotation of the frame pattern that each observed bitslip pulse undoes by one
// bit. The sample path is checked against the value driven one cycle earlier.
// -----------------------------------------------------------------------------
module tb_adc_frame_align;

    localparam logic [7:0] PAT        = 8'hF0;
    localparam int         SLIP_WAIT  = 4;
    localparam int         MATCH_CNT  = 16;
    localparam int         MAX_SLIPS  = 8;
    localparam int         ATTEMPT    = SLIP_WAIT + 2;  // settle + check + slip

    logic        divclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [7:0]  frame_word = PAT;
    logic [63:0] data_in = '0;
    logic        bitslip;
    logic        aligned;
    logic        align_fail;
    logic [3:0]  slip_count;
    logic [15:0] err_count;
    logic [63:0] data_out;
    logic        data_valid;

    adc_frame_align dut (
        .divclk     (divclk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_word (frame_word),
        .data_in    (data_in),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_fail (align_fail),
        .slip_count (slip_count),
        .err_count  (err_count),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 divclk = ~divclk;

    int checks   = 0;
    int failures = 0;

    // Reference-model state.
    int          rot;          // current rotation of the frame lane
    bit          rot_mode;     // frame_word follows the rotation model
    bit          data_chk;     // compare data_out with the previous data_in
    logic [63:0] exp_data = '0;
    logic [7:0]  base;
    int          cyc;
    int          pulses;
    int          wide_errs;
    int          gap_errs;
    int          last_pulse;
    bit          prev_bs;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        int s;
        s = n % 8;
        if (s == 0) return v;
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] v;
        v = 8'($urandom);
        if (v == PAT) v = v ^ 8'h01;
        return v;
    endfunction

    task automatic clear_stats();
        pulses     = 0;
        wide_errs  = 0;
        gap_errs   = 0;
        last_pulse = -1;
        prev_bs    = 1'b0;
    endtask

    // One divclk cycle: observe outputs at the falling edge, update the
    // ISERDES model, then drive the next inputs.
    task automatic tick();
        @(negedge divclk);
        cyc++;
        check("dv_eq_aligned", data_valid, aligned);
        if (bitslip) begin
            pulses++;
            if (prev_bs) wide_errs++;
            if (last_pulse >= 0 && (cyc - last_pulse - 1) < SLIP_WAIT + 1) gap_errs++;
            last_pulse = cyc;
            if (rot_mode) rot = (rot + 7) % 8;
        end
        prev_bs = bitslip;
        if (rot_mode) frame_word = rotl8(PAT, rot);
        if (data_chk) begin
            check("data_out", data_out, exp_data);
            check("data_valid_locked", data_valid, 1);
        end
        base = base + 8'd1;
        for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = base + 8'(i);
        exp_data = data_in;
    endtask

    // Hold start for n cycles; returns just after the last start edge.
    task automatic do_start(input int n);
        start = 1'b1;
        repeat (n) tick();
        start = 1'b0;
    endtask

    // Edges until aligned (sel 0) or align_fail (sel 1); budget on timeout.
    task automatic wait_sig(input int sel, input int budget, output int k);
        k = 0;
        while (k < budget && !((sel == 0) ? aligned : align_fail)) begin
            tick();
            k++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"},    bitslip,    0);
        check({tag, "_aligned"},    aligned,    0);
        check({tag, "_align_fail"}, align_fail, 0);
        check({tag, "_slip_count"}, slip_count, 0);
        check({tag, "_err_count"},  err_count,  0);
        check({tag, "_data_out"},   data_out,   0);
        check({tag, "_data_valid"}, data_valid, 0);
    endtask

    initial begin
        int k;
        int r;
        logic [15:0] err_exp;

        base     = 8'($urandom);
        rot      = 0;
        rot_mode = 1'b0;
        data_chk = 1'b0;
        cyc      = 0;
        clear_stats();

        // ---- reset state ----
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_aligned", aligned, 0);
        check("idle_bitslip_cnt", pulses, 0);

        // ---- clean lock ----
        frame_word = PAT;
        clear_stats();
        do_start(1);
        wait_sig(0, 100, k);
        check("clean_lock_latency", k, SLIP_WAIT + MATCH_CNT);
        check("clean_no_bitslip", pulses, 0);
        check("clean_slip_count", slip_count, 0);
        check("clean_data_valid", data_valid, 1);

        // ---- data path while locked ----
        data_chk = 1'b1;
        repeat (32) tick();
        data_chk = 1'b0;

        // ---- multi-cycle start: latency counts from the last start cycle ----
        clear_stats();
        do_start(3);
        check("restart_clears_aligned", aligned, 0);
        wait_sig(0, 100, k);
        check("multi_start_latency", k, SLIP_WAIT + MATCH_CNT);

        // ---- rotated frame lane: 3, then random rotations ----
        for (int t = 0; t < 5; t++) begin
            r = (t == 0) ? 3 : int'($urandom_range(1, 7));
            rot        = r;
            rot_mode   = 1'b1;
            frame_word = rotl8(PAT, r);
            clear_stats();
            do_start(1);
            wait_sig(0, 200, k);
            check("rot_lock_latency", k, ATTEMPT * r + SLIP_WAIT + MATCH_CNT);
            check("rot_pulses", pulses, r);
            check("rot_slip_count", slip_count, r);
            check("rot_pulse_width", wide_errs, 0);
            check("rot_pulse_gap", gap_errs, 0);
            rot_mode = 1'b0;
        end

        // ---- frame lane stuck: failure after MAX_SLIPS ----
        frame_word = 8'h00;
        clear_stats();
        do_start(1);
        wait_sig(1, 300, k);
        check("fail_latency", k, ATTEMPT * MAX_SLIPS + SLIP_WAIT + 1);
        check("fail_pulses", pulses, MAX_SLIPS);
        check("fail_slip_count", slip_count, MAX_SLIPS);
        check("fail_aligned", aligned, 0);
        repeat (40) tick();
        check("fail_sticky", align_fail, 1);
        check("fail_no_more_slips", pulses, MAX_SLIPS);
        check("fail_still_unaligned", aligned, 0);
        do_start(1);
        check("restart_clears_fail", align_fail, 0);
        check("restart_clears_slips", slip_count, 0);

        // ---- loss of lock ----
        frame_word = PAT;
        clear_stats();
        do_start(1);
        wait_sig(0, 100, k);
        check("relock_latency", k, SLIP_WAIT + MATCH_CNT);
        err_exp = 16'd0;
        for (int i = 0; i < 3; i++) begin
            frame_word = bad_word();
            tick();
            err_exp++;
            frame_word = PAT;
            check("iso_aligned", aligned, 1);
            check("iso_err_count", err_count, err_exp);
            repeat ($urandom_range(1, 4)) tick();
        end
        for (int j = 0; j < 4; j++) begin
            frame_word = bad_word();
            tick();
            err_exp++;
            check("burst_aligned", aligned, (j < 3) ? 1 : 0);
            check("burst_err_count", err_count, err_exp);
        end
        frame_word = PAT;
        check("loss_data_valid", data_valid, 0);
        wait_sig(0, 100, k);
        check("retrain_latency", k, SLIP_WAIT + MATCH_CNT);
        check("retrain_err_kept", err_count, 16'd7);
        check("retrain_slip_count", slip_count, 0);

        // ---- async reset mid-CHECK ----
        frame_word = 8'h00;
        do_start(1);
        repeat (SLIP_WAIT) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_check");
        tick();
        rst_n = 1'b1;

        // ---- async reset during a SLIP cycle ----
        clear_stats();
        do_start(1);
        repeat (SLIP_WAIT + 1) tick();
        check("slip_cycle_bitslip", bitslip, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_slip");
        tick();
        rst_n = 1'b1;
        clear_stats();
        repeat (20) tick();
        check("post_rst_idle_slips", pulses, 0);
        check("post_rst_idle_aligned", aligned, 0);
        check("post_rst_idle_slip_count", slip_count, 0);
        check("post_rst_idle_fail", align_fail, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_frame_align.md
Name: adc_frame_align

Overview:
- Word-alignment controller in the ADC capture path, directly downstream of the LVDS SERDES clocking block.
- Runs on the divided SERDES clock. Watches the deserialized ADC frame-clock lane and pulses the ISERDES bitslip input until the frame word matches the expected pattern.
- Monitors lock continuously and retrains after a loss of lock.
- Registers the 8-lane sample bus and qualifies it with data_valid for the downstream FIFO.

Parameters:
- FRAME_PATTERN, 8'hF0: expected deserialized frame-lane word when aligned.
- SLIP_WAIT, 4: divclk cycles to ignore after start or bitslip (ISERDES pipeline settle); range 1..15.
- MATCH_COUNT, 16: consecutive matches needed to declare lock; range 1..255.
- MAX_SLIPS, 8: bitslips attempted before declaring failure; range 1..15.
- LOSS_COUNT, 4: consecutive mismatches while locked that drop lock; range 1..15.

Ports:
- divclk, in, 1: divided SERDES clock; the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle request to (re)start training; accepted in any state.
- frame_word, in, 8: deserialized frame-clock lane word from ISERDES.
- data_in, in, 64: deserialized sample lanes, 8 lanes x 8 bits.
- bitslip, out, 1: one-cycle bitslip pulse to all ISERDES instances.
- aligned, out, 1: high while locked.
- align_fail, out, 1: high after MAX_SLIPS slips without lock; sticky.
- slip_count, out, 4: bitslips issued in the current training attempt.
- err_count, out, 16: saturating count of frame mismatches while locked.
- data_out, out, 64: data_in delayed by one cycle.
- data_valid, out, 1: qualifies data_out.

Behaviour:
- Reset (async, rst_n low): state IDLE; every output 0; internal counters 0.
- Outputs are registered. Every transition happens on the divclk rising edge.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- start is highest priority, in any state. On the edge it is sampled:
  - go to SETTLE;
  - clear aligned, align_fail, slip_count, err_count, the match counter and the miss counter;
  - bitslip goes 0.
- IDLE: wait for start. aligned = 0, data_valid = 0.
- SETTLE: count SLIP_WAIT cycles with frame_word ignored, then go to CHECK.
- CHECK: compare frame_word with FRAME_PATTERN every cycle.
  - Match: increment the match counter. On the MATCH_COUNT-th consecutive match, go to LOCKED; aligned is high from that edge.
  - Mismatch: clear the match counter. If slip_count == MAX_SLIPS, go to FAIL; otherwise go to SLIP.
- SLIP: lasts one cycle.
  - bitslip is high for exactly that one cycle.
  - slip_count increments on entry.
  - Next state is SETTLE.
  - Back-to-back bitslip pulses are always separated by at least SLIP_WAIT+1 low cycles.
- LOCKED:
  - Match: clear the miss counter.
  - Mismatch: err_count increments, saturating at 16'hFFFF, and the miss counter increments.
  - On the LOSS_COUNT-th consecutive mismatch: aligned is cleared on that edge, slip_count, the match counter and the miss counter are cleared, err_count is retained, and the next state is SETTLE.
- FAIL: align_fail = 1 and aligned = 0. Stays in FAIL until start or reset.
- Data path:
  - data_out <= data_in on every edge, one-cycle latency.
  - data_valid <= (next state is LOCKED), so data_valid and aligned are always equal.
  - data_out is not gated; consumers use data_valid.
- slip_count saturates at MAX_SLIPS and never wraps.
- start asserted for multiple cycles: each cycle restarts. SETTLE begins counting from the last start cycle.

Test Plan:
- Reset, pulse start with frame_word held at 8'hF0:
  - aligned rises exactly SLIP_WAIT+MATCH_COUNT = 20 edges after start is sampled;
  - bitslip never pulses; slip_count = 0; data_valid tracks aligned.
- Model the bitslip rotation, with frame_word initially 8'hF0 rotated by 3:
  - exactly 3 bitslip pulses, each one cycle wide, separated by at least 5 low cycles;
  - lock follows with slip_count = 3.
- Hold frame_word at 8'h00:
  - 8 bitslip pulses are issued, then align_fail = 1 and aligned = 0, held indefinitely;
  - a new start clears align_fail and slip_count.
- While locked, inject 3 isolated mismatches, then 4 consecutive mismatches:
  - aligned stays high through the isolated ones, with err_count = 3;
  - on the 4th consecutive mismatch aligned drops, err_count = 7, and retraining starts in SETTLE.
- Assert rst_n low mid-CHECK and during a SLIP cycle:
  - all outputs go to 0 asynchronously, bitslip included;
  - after release the state stays IDLE until start.
- While locked, drive data_in with an incrementing pattern: data_out equals data_in delayed by one cycle, and data_valid = 1.
